shared_cnt_sched: RTL and testbench

Round-robin scheduler that time-shares a single up-counter among `NREQ` requesters. Each requester asks for a delay of `len` cycles. The block grants the counter to one requester at a time, runs it from 0 up to the latched `len`, and pulses `done` to the owner. It sits between several timing consumers and the one free-running-style counter resource, so the consumers never need their own counters.

---
 rtl/shared_cnt_sched.sv | 120 ++++++++++++
 tb/tb_shared_cnt_sched.sv | 187 ++++++++++++++++++
 2 files changed

// File: rtl/shared_cnt_sched.sv
// Round-robin scheduler sharing one up-counter among NREQ requesters.
// The owner's counter runs 0..len, then done pulses to the owner.
module shared_cnt_sched #(
  parameter int NREQ = 4,
  parameter int CW   = 4
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic [NREQ-1:0]    req,
  input  logic [NREQ*CW-1:0] req_len,
  output logic [NREQ-1:0]    gnt,
  output logic [NREQ-1:0]    done,
  output logic               busy,
  output logic [CW-1:0]      o_cnt
);

  localparam int IW = (NREQ > 1) ? $clog2(NREQ) : 1;
  localparam logic [IW-1:0] LAST_RST = IW'(NREQ - 1);

  typedef enum logic [1:0] {
    IDLE,
    COUNT,
    DONE
  } state_t;

  state_t          state;
  state_t          nxt_state;
  logic [IW-1:0]   last;
  logic [IW-1:0]   nxt_last;
  logic [IW-1:0]   owner;
  logic [IW-1:0]   nxt_owner;
  logic [IW-1:0]   win;
  logic            found;
  logic [CW-1:0]   limit;
  logic [CW-1:0]   nxt_limit;
  logic [CW-1:0]   cnt;
  logic [CW-1:0]   nxt_cnt;
  logic [NREQ-1:0] gnt_q;
  logic [NREQ-1:0] nxt_gnt;
  logic [NREQ-1:0] done_q;
  logic [NREQ-1:0] nxt_done;
  int              idx;

  // Walk farthest-to-nearest so the nearest requester after last wins.
  always_comb begin
    found = 1'b0;
    win   = last;
    idx   = 0;
    for (int off = NREQ; off >= 1; off--) begin
      idx = int'(last) + off;
      if (idx >= NREQ) idx = idx - NREQ;
      if (req[idx]) begin
        found = 1'b1;
        win   = IW'(idx);
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state  <= IDLE;
      last   <= LAST_RST;
      owner  <= '0;
      limit  <= '0;
      cnt    <= '0;
      gnt_q  <= '0;
      done_q <= '0;
    end else begin
      state  <= nxt_state;
      last   <= nxt_last;
      owner  <= nxt_owner;
      limit  <= nxt_limit;
      cnt    <= nxt_cnt;
      gnt_q  <= nxt_gnt;
      done_q <= nxt_done;
    end
  end

  always_comb begin
    nxt_state = state;
    nxt_last  = last;
    nxt_owner = owner;
    nxt_limit = limit;
    nxt_cnt   = '0;
    nxt_gnt   = '0;
    nxt_done  = '0;
    unique case (state)
      IDLE: begin
        if (found) begin
          nxt_state      = COUNT;
          nxt_last       = win;
          nxt_owner      = win;
          nxt_limit      = req_len[int'(win)*CW +: CW];
          nxt_gnt[win]   = 1'b1;
        end
      end
      COUNT: begin
        if (!req[owner]) begin
          nxt_state = IDLE;
        end else if (cnt == limit) begin
          nxt_state       = DONE;
          nxt_done[owner] = 1'b1;
        end else begin
          nxt_cnt = cnt + 1'b1;
          nxt_gnt = gnt_q;
        end
      end
      DONE: nxt_state = IDLE;
      default: nxt_state = IDLE;
    endcase
  end

  always_comb begin
    gnt   = gnt_q;
    done  = done_q;
    busy  = (state != IDLE);
    o_cnt = cnt;
  end

endmodule

// File: tb/tb_shared_cnt_sched.sv
// Bench for shared_cnt_sched: directed plan plus random traffic,
// checked cycle by cycle against a transaction-level model.
module tb_shared_cnt_sched;

  localparam int N  = 4;
  localparam int CW = 4;

  logic            clk = 1'b0;
  logic            rst_n = 1'b0;
  logic [N-1:0]    req = '0;
  logic [N*CW-1:0] req_len = '0;
  logic [N-1:0]    gnt;
  logic [N-1:0]    done;
  logic            busy;
  logic [CW-1:0]   o_cnt;

  int checks = 0;
  int failures = 0;
  int cyc = 0;

  int m_own = -1;
  int m_cnt = 0;
  int m_lim = 0;
  int m_last = N - 1;
  int m_done = 0;

  int          g_who[$];
  int          g_when[$];
  logic [N-1:0] prev_gnt = '0;
  int          max_cnt;
  logic [N-1:0] done_seen;

  shared_cnt_sched #(.NREQ(N), .CW(CW)) dut (
    .clk(clk), .rst_n(rst_n), .req(req), .req_len(req_len),
    .gnt(gnt), .done(done), .busy(busy), .o_cnt(o_cnt)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs,
                     input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s cyc=%0d obs=%0h exp=%0h", tag, cyc, obs, exp);
    end
  endtask

  function automatic int len_of(input int i);
    logic [N*CW-1:0] v;
    v = req_len;
    return int'(v[i*CW +: CW]);
  endfunction

  // Whole-transaction view: who owns the counter, how far it got.
  task automatic model_edge();
    if (!rst_n) begin
      m_own = -1; m_cnt = 0; m_done = 0; m_last = N - 1;
    end else if (m_done != 0) begin
      m_done = 0;
    end else if (m_own < 0) begin
      for (int k = 1; k <= N; k++) begin
        int c;
        c = (m_last + k) % N;
        if (m_own < 0 && req[c]) begin
          m_own = c; m_lim = len_of(c); m_cnt = 0; m_last = c;
        end
      end
    end else if (!req[m_own]) begin
      m_own = -1; m_cnt = 0;
    end else if (m_cnt == m_lim) begin
      m_done = 1 << m_own; m_own = -1; m_cnt = 0;
    end else begin
      m_cnt++;
    end
  endtask

  task automatic tick();
    int eg;
    @(posedge clk);
    model_edge();
    cyc++;
    #1;
    eg = (m_own >= 0) ? (1 << m_own) : 0;
    chk("gnt", 32'(gnt), 32'(eg));
    chk("done", 32'(done), 32'(m_done));
    chk("busy", 32'(busy), 32'((m_own >= 0) || (m_done != 0)));
    chk("o_cnt", 32'(o_cnt), 32'(m_cnt));
    if (gnt != 0 && prev_gnt == 0) begin
      for (int i = 0; i < N; i++)
        if (gnt[i]) g_who.push_back(i);
      g_when.push_back(cyc);
    end
    prev_gnt = gnt;
    if (int'(o_cnt) > max_cnt) max_cnt = int'(o_cnt);
    done_seen = done_seen | done;
  endtask

  task automatic set_len(input int i, input int v);
    req_len[i*CW +: CW] = CW'(v);
  endtask

  initial begin
    // reset with all requests up
    rst_n = 1'b0;
    req = 4'b1111;
    repeat (3) tick();
    // single request, len 3
    rst_n = 1'b1;
    req = 4'b0001;
    set_len(0, 3);
    repeat (4) tick();
    chk("single_cnt3", 32'(o_cnt), 32'd3);
    tick();
    chk("single_done", 32'(done), 32'b0001);
    req = '0;
    tick();
    chk("single_idle", 32'(busy), 32'd0);
    // fairness after pointer reset
    rst_n = 1'b0;
    tick();
    rst_n = 1'b1;
    req_len = '0;
    req = 4'b1111;
    g_who.delete();
    g_when.delete();
    repeat (16) tick();
    chk("fair_n", 32'(g_who.size() >= 5), 32'd1);
    if (g_who.size() >= 5) begin
      for (int i = 0; i < 5; i++)
        chk("fair_order", 32'(g_who[i]), 32'(i % N));
      for (int i = 1; i < 5; i++)
        chk("fair_gap", 32'(g_when[i] - g_when[i-1]), 32'd3);
    end
    req = '0;
    repeat (3) tick();
    // abort with a length change after grant
    req = 4'b0100;
    set_len(2, 10);
    for (int n = 0; n < 10 && !gnt[2]; n++) tick();
    chk("abort_gnt", 32'(gnt), 32'b0100);
    set_len(2, 1);
    for (int n = 0; n < 10 && o_cnt != 4; n++) tick();
    chk("abort_cnt4", 32'(o_cnt), 32'd4);
    req = '0;
    done_seen = '0;
    tick();
    chk("abort_busy", 32'(busy), 32'd0);
    repeat (3) tick();
    chk("abort_nodone", 32'(done_seen), 32'd0);
    // full-scale length
    req = 4'b0010;
    set_len(1, 15);
    max_cnt = 0;
    done_seen = '0;
    for (int n = 0; n < 30 && done_seen == 0; n++) tick();
    chk("full_max", 32'(max_cnt), 32'd15);
    chk("full_done", 32'(done_seen), 32'b0010);
    req = '0;
    repeat (2) tick();
    // reset mid-count resets the pointer too
    req = 4'b0001;
    set_len(0, 12);
    for (int n = 0; n < 20 && o_cnt != 7; n++) tick();
    chk("mid_cnt7", 32'(o_cnt), 32'd7);
    rst_n = 1'b0;
    tick();
    chk("mid_rst", 32'({gnt, done, busy, o_cnt}), 32'd0);
    rst_n = 1'b1;
    req = 4'b0011;
    tick();
    chk("mid_regnt", 32'(gnt), 32'b0001);
    // random traffic
    for (int n = 0; n < 600; n++) begin
      for (int i = 0; i < N; i++) begin
        if ($urandom_range(0, 9) == 0) req[i] = ~req[i];
        if (done[i] && $urandom_range(0, 1) == 0) req[i] = 1'b0;
        if ($urandom_range(0, 5) == 0) set_len(i, $urandom_range(0, 15));
      end
      rst_n = ($urandom_range(0, 99) != 0);
      tick();
    end
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
